// File: rtl/kvs_stream_sequencer.sv
// kvs_stream_sequencer
// Per-run controller between the read-side stream FIFO, the KVS engine and
// the write-side stream FIFO. A run latches a byte count on ap_start, turns it
// into a word count, passes exactly that many command words to the engine
// under a credit limit, forwards exactly that many results to the write FIFO
// and pulses ap_done one cycle after the last result is accepted.

module kvs_stream_sequencer #(
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_MAX_INFLIGHT    = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ap_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ap_done,
  output logic                         busy,
  input  logic                         s_rd_tvalid,
  output logic                         s_rd_tready,
  input  logic [C_DATA_WIDTH-1:0]      s_rd_tdata,
  output logic                         m_eng_tvalid,
  input  logic                         m_eng_tready,
  output logic [C_DATA_WIDTH-1:0]      m_eng_tdata,
  input  logic                         s_eng_tvalid,
  output logic                         s_eng_tready,
  input  logic [C_DATA_WIDTH-1:0]      s_eng_tdata,
  output logic                         m_wr_tvalid,
  input  logic                         m_wr_tready,
  output logic [C_DATA_WIDTH-1:0]      m_wr_tdata,
  output logic [7:0]                   inflight
);

  localparam int XW             = C_XFER_SIZE_WIDTH;
  localparam int BYTES_PER_WORD = C_DATA_WIDTH / 8;
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  // Low byte-address bits that fall inside one word; any of them set means a
  // partial trailing word that still costs a full word.
  localparam logic [XW-1:0] REM_MASK     = ~({XW{1'b1}} << WORD_SHIFT);
  localparam logic [7:0]    MAX_INFLIGHT = 8'(C_MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [XW-1:0] bytes_q;
  logic [XW-1:0] words_q;
  logic [XW-1:0] words_calc;
  logic [XW-1:0] issued_cnt;
  logic [XW-1:0] retired_cnt;
  logic [7:0]    inflight_q;
  logic          issue_ok;
  logic          ret_ok;
  logic          issue;
  logic          retire;

  // Ceiling division by the word size: whole words plus one for any remainder.
  assign words_calc = (bytes_q >> WORD_SHIFT) + XW'(|(bytes_q & REM_MASK));

  // Issue side: zero-latency passthrough gated by word budget and credits.
  // The credit test uses the registered count, so a retire in the same cycle
  // does not open an extra slot until the next cycle.
  assign issue_ok     = (state == RUN) && (issued_cnt < words_q) && (inflight_q < MAX_INFLIGHT);
  assign m_eng_tvalid = s_rd_tvalid & issue_ok;
  assign s_rd_tready  = m_eng_tready & issue_ok;
  assign m_eng_tdata  = s_rd_tdata;
  assign issue        = s_rd_tvalid & s_rd_tready;

  // Retire side: results are only taken while something is outstanding, so
  // stray results are back-pressured rather than dropped.
  assign ret_ok       = (state == RUN) && (inflight_q != 8'd0);
  assign m_wr_tvalid  = s_eng_tvalid & ret_ok;
  assign s_eng_tready = m_wr_tready & ret_ok;
  assign m_wr_tdata   = s_eng_tdata;
  assign retire       = s_eng_tvalid & s_eng_tready;

  assign ap_done  = (state == DONE);
  assign busy     = (state != IDLE);
  assign inflight = inflight_q;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a run ends on the retire that completes the word count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ap_start) state_next = LOAD;
      LOAD:    state_next = (words_calc == '0) ? DONE : RUN;
      RUN:     if (retire && (retired_cnt == (words_q - XW'(1)))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte count is captured only from an accepted start; later starts are ignored.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bytes_q <= '0;
    end else if ((state == IDLE) && ap_start) begin
      bytes_q <= ctrl_xfer_size_in_bytes;
    end
  end

  // Word budget and progress counters, restarted for every run in LOAD.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      words_q     <= '0;
      issued_cnt  <= '0;
      retired_cnt <= '0;
      inflight_q  <= '0;
    end else if (state == LOAD) begin
      words_q     <= words_calc;
      issued_cnt  <= '0;
      retired_cnt <= '0;
      inflight_q  <= '0;
    end else if (state == RUN) begin
      issued_cnt  <= issued_cnt + XW'(issue);
      retired_cnt <= retired_cnt + XW'(retire);
      case ({issue, retire})
        2'b10:   inflight_q <= inflight_q + 8'd1;
        2'b01:   inflight_q <= inflight_q - 8'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule
